// File: rtl/prio_codec_pkg.sv
// rtl/prio_codec_pkg.sv - shared widths, state encoding and one-hot helper for the index codec path
package prio_codec_pkg;

  localparam int IDX_W_DEFAULT = 3;
  localparam int VEC_W_DEFAULT = 2 ** IDX_W_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Expand an encoded index back into its single request bit.
  function automatic logic [VEC_W_DEFAULT-1:0] onehot(input logic [IDX_W_DEFAULT-1:0] idx);
    logic [VEC_W_DEFAULT-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at its all-ones value
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment; the count never wraps past MAX.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/index_vector_decoder.sv
// rtl/index_vector_decoder.sv - rebuilds the OR'd request mask, beat count and duplicate flag of an index frame
module index_vector_decoder
  import prio_codec_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**IDX_W)-1:0] out_mask,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_dup
);

  localparam int VEC_W = 2 ** IDX_W;

  state_e           state_q;
  logic [VEC_W-1:0] acc_mask_q;
  logic [VEC_W-1:0] acc_mask_d;
  logic             acc_dup_q;
  logic             acc_dup_d;
  logic             out_valid_q;
  logic [VEC_W-1:0] beat_bit;
  logic             beat;
  logic             xfer;

  generate
    if (IDX_W == IDX_W_DEFAULT) begin : g_pkg_onehot
      assign beat_bit = onehot(in_idx);
    end else begin : g_shift_onehot
      assign beat_bit = VEC_W'(1) << in_idx;
    end
  endgenerate

  // Input is stalled for as long as a summary is waiting downstream.
  assign in_ready = (state_q != HOLD);
  assign beat     = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  // Fold the incoming bit into the mask; a bit already present marks a duplicate.
  always_comb begin
    acc_mask_d = acc_mask_q | beat_bit;
    acc_dup_d  = acc_dup_q || (|(acc_mask_q & beat_bit));
  end

  // Frame FSM: accumulate until the last beat, then hold the summary until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_mask_q  <= '0;
      acc_dup_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            acc_mask_q <= acc_mask_d;
            acc_dup_q  <= acc_dup_d;
            if (in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_mask_q  <= '0;
            acc_dup_q   <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_mask_q  <= '0;
          acc_dup_q   <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_beat_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (xfer),
    .inc  (beat),
    .count(out_count)
  );

  assign out_valid = out_valid_q;
  assign out_mask  = acc_mask_q;
  assign out_dup   = acc_dup_q;

endmodule

// File: tb/tb_index_vector_decoder.sv
// tb/tb_index_vector_decoder.sv - scoreboard bench for the index vector decoder
module tb_index_vector_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_idx = 3'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       out_dup;

  int checks = 0;
  int errors = 0;
  bit auto_rdy = 1'b0;

  typedef struct {
    logic [7:0] mask;
    int         cnt;
    bit         dup;
  } sum_t;

  sum_t exp_q[$];
  bit   seen[8];
  int   m_cnt = 0;
  bit   m_dup = 1'b0;

  index_vector_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mask (out_mask),
    .out_count(out_count),
    .out_dup  (out_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    m_cnt = 0;
    m_dup = 1'b0;
  endtask

  task automatic model_beat(input int idx, input bit last);
    sum_t s;
    if (seen[idx]) m_dup = 1'b1;
    seen[idx] = 1'b1;
    m_cnt++;
    if (last) begin
      s.mask = 8'd0;
      for (int i = 0; i < 8; i++) if (seen[i]) s.mask = s.mask + 8'(1 << i);
      s.cnt = (m_cnt > 15) ? 15 : m_cnt;
      s.dup = m_dup;
      exp_q.push_back(s);
      model_clear();
    end
  endtask

  // Present one beat (called just after a rising edge) and wait until it is taken.
  task automatic send_beat(input int idx, input bit last, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_idx   = 3'(idx);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("beat_timeout", 1'b0, waited, 200);
    else model_beat(idx, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_summary(input string name, input int mask, input int cnt, input bit dup);
    int w = 0;
    @(negedge clk);
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_valid"}, out_valid == 1'b1, out_valid, 1);
    chk({name, "_mask"}, out_mask == 8'(mask), out_mask, mask);
    chk({name, "_count"}, out_count == 4'(cnt), out_count, cnt);
    chk({name, "_dup"}, out_dup == dup, out_dup, dup);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented summary must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_summary", 1'b0, out_mask, 0);
      end else begin
        chk("sb_mask", out_mask == exp_q[0].mask, out_mask, exp_q[0].mask);
        chk("sb_count", out_count == 4'(exp_q[0].cnt), out_count, exp_q[0].cnt);
        chk("sb_dup", out_dup == exp_q[0].dup, out_dup, exp_q[0].dup);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Random downstream back-pressure once enabled.
  always @(posedge clk) begin
    if (auto_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int len;
    int gap;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    chk("rst_valid", out_valid == 1'b0, out_valid, 0);
    chk("rst_ready", in_ready == 1'b1, in_ready, 1);
    chk("rst_mask", out_mask == 8'd0, out_mask, 0);
    chk("rst_count", out_count == 4'd0, out_count, 0);
    chk("rst_dup", out_dup == 1'b0, out_dup, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    send_beat(7, 1'b0, w);
    send_beat(2, 1'b0, w);
    send_beat(0, 1'b1, w);
    @(negedge clk);
    chk("lat_valid", out_valid == 1'b1, out_valid, 1);
    chk("lat_ready", in_ready == 1'b0, in_ready, 0);
    chk("f1_mask", out_mask == 8'b1000_0101, out_mask, 8'b1000_0101);
    chk("f1_count", out_count == 4'd3, out_count, 3);
    chk("f1_dup", out_dup == 1'b0, out_dup, 0);
    @(negedge clk);
    chk("post_valid", out_valid == 1'b0, out_valid, 0);
    chk("post_ready", in_ready == 1'b1, in_ready, 1);
    @(posedge clk);
    #1;

    send_beat(5, 1'b1, w);
    wait_summary("single", 8'b0010_0000, 1, 1'b0);

    send_beat(3, 1'b0, w);
    send_beat(3, 1'b0, w);
    send_beat(6, 1'b1, w);
    wait_summary("dup", 8'b0100_1000, 3, 1'b1);

    out_ready = 1'b0;
    send_beat(4, 1'b1, w);
    in_valid = 1'b1;
    in_idx   = 3'd1;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_ready", in_ready == 1'b0, in_ready, 0);
      chk("stall_valid", out_valid == 1'b1, out_valid, 1);
      chk("stall_mask", out_mask == 8'b0001_0000, out_mask, 8'b0001_0000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(1, 1'b1, w);
    chk("stall_accept_wait", w == 1, w, 1);
    wait_summary("after_stall", 8'b0000_0010, 1, 1'b0);

    for (int i = 0; i < 20; i++) send_beat(i % 8, i == 19, w);
    wait_summary("sat", 8'hFF, 15, 1'b1);

    send_beat(1, 1'b0, w);
    send_beat(2, 1'b0, w);
    reset = 1'b1;
    model_clear();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_beat(4, 1'b1, w);
    wait_summary("post_reset", 8'b0001_0000, 1, 1'b0);

    auto_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) send_beat($urandom_range(0, 7), b == len - 1, w);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", exp_q.size() == 0, exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/index_vector_decoder.md
Name: index_vector_decoder

Overview:
- Inverse of the team's 8-input priority encoder path: consumes a stream of encoded 3-bit indices (one per accepted beat, frame delimited by in_last) and rebuilds the 8-bit one-hot-OR vector they represent.
- Emits one registered frame summary per frame: mask, beat count, duplicate flag.
- Sits downstream of encoder/arbiter logic and reconstructs request masks for checking or replay.

Parameters:
- IDX_W, 3, index width; VEC_W = 2**IDX_W (8 at default), derived localparam, not overridable.
- CNT_W, 4, beat-count width; count saturates at 2**CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  index beat valid
- in_ready  output  1  decoder can accept a beat this cycle
- in_idx  input  IDX_W  encoded index
- in_last  input  1  final beat of frame
- out_valid  output  1  frame summary valid
- out_ready  input  1  downstream accepts summary
- out_mask  output  VEC_W  OR of one-hot(in_idx) over the frame
- out_count  output  CNT_W  accepted beats in frame, saturating
- out_dup  output  1  some index appeared more than once in the frame

Behaviour:
- Single clock. Reset is synchronous, active-high, and highest priority.
- Reset values: state=IDLE, out_valid=0, out_mask=0, out_count=0, out_dup=0, internal accumulators=0. in_ready is 1 after reset.
- A beat is accepted when in_valid && in_ready. The summary is transferred when out_valid && out_ready.
- in_ready = (state != HOLD). Input is fully stalled while a summary is pending. There is no bypass.
- States:
  - IDLE: accumulators zero. Accepted beat without last -> ACCUM. Accepted beat with last -> HOLD.
  - ACCUM: each accepted beat ORs 1<<in_idx into acc_mask and increments acc_cnt (saturating). acc_dup is set if that bit was already 1 before the OR. Accepted beat with last -> HOLD.
  - HOLD: out_valid=1, outputs stable and unchanged while out_ready=0. On transfer -> IDLE and accumulators clear in the same edge.
- Latency: the last beat accepted at edge N gives out_valid=1 after edge N. The summary includes the last beat.
- After transfer at edge M, in_ready=1 after edge M. Back-to-back frames therefore cost 1 bubble cycle minimum.
- Single-beat frame (last on first beat): out_mask = one-hot(in_idx), out_count=1, out_dup=0.
- Saturation: out_count holds at 2**CNT_W-1 (15) and never wraps. The mask keeps accumulating.
- out_ready while out_valid=0 has no effect.
- in_valid=1 during HOLD: not accepted, and in_idx/in_last are ignored. The upstream must hold the beat.
- in_idx values are always in range (IDX_W bits cover VEC_W exactly). No error path.
- Reset mid-frame or during HOLD: the partial frame and any pending summary are discarded. No output beat is emitted.
- out_* are driven from registers. No combinational path from in_* to out_*. in_ready depends only on state.

Decomposition:
- Shared package `prio_codec_pkg`:
  - IDX_W/VEC_W defaults
  - state enum {IDLE, ACCUM, HOLD}
  - function onehot(idx) returning VEC_W bits
- One natural sub-module, `sat_counter` (parameter width; inputs clr, inc; output saturating count), used for the beat count.
- Everything else stays in the top.

Test Plan:
- Reset, then frame idx 7,2,0 (last on 0), out_ready=1 -> out_mask=8'b1000_0101, out_count=3, out_dup=0, out_valid one cycle after last beat, in_ready low for exactly that cycle.
- Single-beat frame idx=5 with last -> out_mask=8'b0010_0000, out_count=1, out_dup=0.
- Frame idx 3,3,6 -> out_mask=8'b0100_1000, out_count=3, out_dup=1.
- Summary pending with out_ready=0 for 5 cycles while in_valid=1 (idx=1) -> outputs stable, in_ready=0, no beat consumed. Raise out_ready -> transfer, then the idx=1 beat is accepted on the following cycle.
- 20-beat frame cycling idx 0..7 -> out_mask=8'hFF, out_count=15 (saturated), out_dup=1.
- Assert reset after 2 beats of a frame, then send a fresh frame idx=4 with last -> only out_mask=8'b0001_0000, out_count=1. No stale bits and no summary for the aborted frame.
